// File: rtl/sdp_write_queue.sv
// Write queue in front of the OPL3 register file: FIFO control around a simple dual-port RAM,
// with the RAM read latency hidden behind valid/ready and a programmable idle gap between pops.

module mem_simple_dual_port #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int OUTPUT_DELAY = 1
) (
  input  logic                  clka,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dia,
  input  logic                  clkb,
  input  logic                  reb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] dob
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clka) begin
    if (wea) mem[addra] <= dia;
  end

  generate
    if (OUTPUT_DELAY == 0) begin : g_d0
      assign dob = mem[addrb];
    end else begin : g_dreg
      logic [DATA_WIDTH-1:0] rd_q;

      always_ff @(posedge clkb) begin
        if (reb) rd_q <= mem[addrb];
      end

      if (OUTPUT_DELAY == 1) begin : g_d1
        assign dob = rd_q;
      end else begin : g_d2
        // second stage follows rd_q every cycle; rd_q only moves on reb, so dob stays stable
        logic [DATA_WIDTH-1:0] pipe_q;
        always_ff @(posedge clkb) pipe_q <= rd_q;
        assign dob = pipe_q;
      end
    end
  endgenerate

endmodule

module sdp_write_queue #(
  parameter int DATA_WIDTH       = 17,
  parameter int DEPTH            = 16,
  parameter int MEM_OUTPUT_DELAY = 1,
  parameter int MIN_GAP          = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, GAP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    gap_q;
  logic          push, pop, reb;

  assign in_ready = (count < CW'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    reb       = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count != '0) begin
          reb     = 1'b1;
          state_d = (MEM_OUTPUT_DELAY == 2) ? FETCH : VALID;
        end
      end
      FETCH: state_d = VALID;
      VALID: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pop     = 1'b1;
          state_d = (MIN_GAP == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // flush discards any concurrent pop and abandons an in-flight read
    if (flush) begin
      state_d = IDLE;
      reb     = 1'b0;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      gap_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (pop)                 gap_q <= 8'(MIN_GAP);
      else if (state_q == GAP) gap_q <= gap_q - 8'd1;
    end
  end

  mem_simple_dual_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (AW),
    .OUTPUT_DELAY(MEM_OUTPUT_DELAY)
  ) u_mem (
    .clka (clk),
    .wea  (push),
    .addra(wr_ptr),
    .dia  (in_data),
    .clkb (clk),
    .reb  (reb),
    .addrb(rd_ptr),
    .dob  (out_data)
  );

endmodule

// File: tb/tb_sdp_write_queue.sv
// Self-checking bench for sdp_write_queue: randomized traffic on a default instance against a
// queue-based timing/order model, plus directed checks on a delay-2, zero-gap instance.

module tb_sdp_write_queue;

  localparam int MG = 4;  // MIN_GAP of the default instance
  localparam int XD = 0;  // extra fetch cycle of the default instance (MEM_OUTPUT_DELAY = 1)

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [16:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [16:0] out_data;
  logic [4:0]  count;

  logic        flush2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [16:0] in_data2 = '0;
  logic        in_ready2, out_valid2;
  logic [16:0] out_data2;
  logic [4:0]  count2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  sdp_write_queue dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  sdp_write_queue #(
    .DATA_WIDTH(17), .DEPTH(16), .MEM_OUTPUT_DELAY(2), .MIN_GAP(0)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .count(count2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: entries carry the cycle they were accepted; the head becomes visible two
  // cycles after its push and 2+MIN_GAP cycles after the previous pop, whichever is later.
  typedef struct {
    logic [16:0] d;
    int          c;
  } ent_t;

  ent_t q[$];
  int   last_pop = -100;

  always @(negedge clk) begin
    int  av;
    bit  exp_vld, exp_rdy;
    if (!reset_n) begin
      q.delete();
      last_pop = -100;
      chk("rst_count", count, 0);
      chk("rst_out_valid", out_valid, 0);
    end else begin
      exp_rdy = (q.size() < 16) && !flush;
      exp_vld = 1'b0;
      if (q.size() > 0) begin
        av = q[0].c + 2 + XD;
        if (last_pop + 2 + MG + XD > av) av = last_pop + 2 + MG + XD;
        exp_vld = (cyc >= av);
      end
      chk("count", count, q.size());
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, exp_vld);
      if (exp_vld) chk("out_data", out_data, q[0].d);
      if (flush) begin
        q.delete();
        last_pop = -100;
      end else begin
        if (exp_vld && out_ready) begin
          void'(q.pop_front());
          last_pop = cyc;
        end
        if (in_valid && exp_rdy) q.push_back('{in_data, cyc});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;

    // single word into empty queue
    step();
    in_valid = 1'b1; in_data = 17'h1ABCD; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();

    // fill to DEPTH with one extra push refused, then drain at gap-limited rate
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 17'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (110) step();

    // simultaneous push and pop at count = 5
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 17'(32'h100 + i);
      step();
    end
    in_valid = 1'b0;
    repeat (5) step();
    in_valid = 1'b1; in_data = 17'h1FFFF; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    out_ready = 1'b1;
    repeat (50) step();

    // random bursts across pointer wrap-around
    begin
      int nxt = 0;
      int budget = 0;
      while (nxt < 40 && budget < 3000) begin
        in_valid  = ($urandom_range(0, 2) != 0);
        in_data   = 17'(32'h2000 + nxt);
        out_ready = ($urandom_range(0, 3) == 0);
        if (in_valid && in_ready) nxt++;
        step();
        budget++;
      end
      if (nxt < 40) begin
        total++; bad++;
        $display("FAIL wrap_budget: got %0d words expected 40", nxt);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (120) step();

    // flush while VALID with count = 7 and a concurrent push/pop
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 17'(32'h700 + i);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    flush = 1'b1; in_valid = 1'b1; in_data = 17'h12345; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    in_valid = 1'b1; in_data = 17'h00055; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();

    // async reset in the middle of a gap
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 17'(32'h300 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    step();
    step();
    reset_n = 1'b1;
    repeat (3) step();

    // delay-2, zero-gap instance: back-to-back pushes
    out_ready2 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_valid2 = (k < 2);
      in_data2  = (k == 0) ? 17'h0AAAA : 17'h0BBBB;
      @(negedge clk);
      chk("d2_valid", out_valid2, (k == 3 || k == 6) ? 1 : 0);
      if (k == 3) chk("d2_data_a", out_data2, 17'h0AAAA);
      if (k == 6) chk("d2_data_b", out_data2, 17'h0BBBB);
      step();
    end
    in_valid2 = 1'b0;

    // delay-2 instance: head held for 10 cycles must stay stable
    for (int k = 0; k < 15; k++) begin
      in_valid2  = (k == 0);
      in_data2   = 17'h1C0DE;
      out_ready2 = (k == 13);
      @(negedge clk);
      if (k < 3) begin
        chk("d2_hold_valid_lo", out_valid2, 0);
      end else if (k <= 13) begin
        chk("d2_hold_valid", out_valid2, 1);
        chk("d2_hold_data", out_data2, 17'h1C0DE);
      end else begin
        chk("d2_after_pop_valid", out_valid2, 0);
        chk("d2_after_pop_count", count2, 0);
        chk("d2_after_pop_in_ready", in_ready2, 1);
      end
      step();
    end
    in_valid2 = 1'b0; out_ready2 = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdp_write_queue.md
Name: sdp_write_queue

Overview:
- Single-clock FIFO controller that sequences one internal mem_simple_dual_port instance as its storage.
- Drives the memory's write port and read port (addra/wea, addrb/reb) and hides the memory's configurable read latency behind a valid/ready output.
- Enforces a programmable minimum idle gap between consecutive pops.
- Sits between the host register-write path and the OPL3 register file: queues {address, data} writes and releases them at a rate the core can absorb.

Parameters:
- DATA_WIDTH, 17, queued word width (9-bit register address + 8-bit data).
- DEPTH, 16, number of entries; power of two, >= 2.
- MEM_OUTPUT_DELAY, 1, OUTPUT_DELAY passed to the memory instance; 0, 1 or 2.
- MIN_GAP, 4, minimum extra idle cycles after each pop; 0 to 255.

Ports:
- clk  in  1  single clock; drives both clka and clkb of the memory.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of queue state.
- in_valid  in  1  push request.
- in_ready  out  1  queue can accept; equals (count < DEPTH) && !flush.
- in_data  in  DATA_WIDTH  word to push.
- out_valid  out  1  head word presented.
- out_ready  in  1  consumer accepts head.
- out_data  out  DATA_WIDTH  head word; driven directly by memory dob.
- count  out  $clog2(DEPTH+1)  entries pushed and not yet popped, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = 0, count = 0, gap counter = 0, FSM = IDLE.
  - out_valid = 0, in_ready = 1 after reset.
  - Memory contents are not cleared.
- Push: in_valid && in_ready at an edge → wea = 1, addra = wr_ptr, dia = in_data; wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready at an edge → rd_ptr increments modulo DEPTH.
- Count:
  - push-only: count + 1; pop-only: count − 1.
  - simultaneous push and pop: count unchanged.
  - push while count == DEPTH: impossible, since in_ready = 0 and in_valid is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- A slot is reusable only after its pop. Since count bounds wr_ptr, the head slot is never overwritten while presented.
- addrb = rd_ptr at all times, so out_data is stable while out_valid = 1 for every MEM_OUTPUT_DELAY value.
- FSM states:
  - IDLE: out_valid = 0. If count > 0 and the pop for rd_ptr is not yet done: reb = 1 for this cycle. Next state is VALID when MEM_OUTPUT_DELAY <= 1, FETCH when MEM_OUTPUT_DELAY = 2. Otherwise stay in IDLE.
  - FETCH: one cycle, out_valid = 0, reb = 0, then VALID.
  - VALID: out_valid = 1. On out_ready: pop, then go to GAP with gap counter = MIN_GAP, or to IDLE if MIN_GAP = 0. Otherwise hold.
  - GAP: out_valid = 0; gap counter decrements each cycle; go to IDLE in the cycle it reads 1.
- Latency:
  - Push into empty queue at edge E: out_valid first high in the cycle after edge E+1 (two cycles after in_valid) for MEM_OUTPUT_DELAY <= 1, one cycle later for MEM_OUTPUT_DELAY = 2.
  - Pop in cycle t: next out_valid no earlier than cycle t + 2 + MIN_GAP, plus 1 when MEM_OUTPUT_DELAY = 2.
  - Peak throughput is one word per (2 + MIN_GAP) cycles.
- out_valid is never deasserted without a pop, except by flush or reset.
- flush:
  - pointers, count and gap counter go to 0; FSM goes to IDLE; out_valid = 0 next cycle.
  - a push presented in the same cycle is rejected, since in_ready = 0 during flush.
  - a pop in the same cycle is discarded; flush wins.
- Reset mid-operation: immediate return to the reset state; any in-flight fetch is abandoned.
- Word ordering is strictly FIFO across pointer wrap-around.

Test Plan:
- Defaults; push 0x1ABCD at cycle 0, out_ready = 1 → out_valid = 1 at cycle 2 with out_data = 0x1ABCD; popped there; count = 0 at cycle 3.
- DEPTH = 16: push 16 words 0x00..0x0F with out_ready = 0 → count = 16, in_ready = 0; a 17th push is ignored; then pop all → exactly 0x00..0x0F in order, out_valid spacing 6 cycles (MIN_GAP = 4).
- Wrap-around: push/pop 40 words (incrementing) in random bursts with random out_ready → output order intact, count never exceeds 16 or underflows.
- Simultaneous push and pop at count = 5 → count stays 5; in_ready stays 1.
- MEM_OUTPUT_DELAY = 2, MIN_GAP = 0: two back-to-back pushes → out_valid at cycles 3 and 6; out_data stable while out_ready is held low for 10 cycles.
- flush asserted while in VALID with count = 7 plus a concurrent push → next cycle count = 0, out_valid = 0; then push 0x00055 → output 0x00055. Async reset_n pulse mid-GAP → immediate out_valid = 0, count = 0.
